// File: rtl/sparc_mac_dp.sv
// sparc_mac_dp: multi-channel multiply-accumulate datapath.
// NCH requesters share one fully pipelined multiplier through a round-robin
// arbiter; every channel owns a private ACCW-bit accumulator that is updated
// in order at retirement, LAT cycles after the grant.
// Optional feature macro: SPARC_MAC_SAT_EN (saturating MAC plus sticky
// per-channel overflow flags). Without it the accumulators wrap and acc_ovf
// is tied low.
module sparc_mac_dp #(
   parameter int WIDTH = 64,
   parameter int NCH   = 2,
   parameter int LAT   = 4,
   parameter int GUARD = 8
) (
   input  logic                   rclk,
   input  logic                   rst_l,
   input  logic                   hold,
   input  logic [NCH-1:0]         req_vld,
   input  logic [2*NCH-1:0]       req_op,
   input  logic [WIDTH*NCH-1:0]   req_op1,
   input  logic [WIDTH*NCH-1:0]   req_op2,
   input  logic [NCH-1:0]         req_sgn,
   input  logic [NCH-1:0]         req_x2,
   output logic [NCH-1:0]         gnt,
   output logic                   out_vld,
   output logic [2:0]             out_ch,
   output logic [WIDTH-1:0]       out_lo,
   output logic [WIDTH-1:0]       out_hi,
   output logic [NCH-1:0]         acc_ovf
);

   localparam int PW   = 2 * WIDTH;
   localparam int ACCW = PW + GUARD;
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int NST  = LAT - 1;
   localparam int LS   = NST - 1;
   localparam logic [ACCW-1:0] P_HIMASK = {ACCW{1'b1}} << PW;

   typedef enum logic [1:0] {
      OP_MUL = 2'b00,
      OP_MAC = 2'b01,
      OP_SHR = 2'b10,
      OP_CLR = 2'b11
   } op_e;

   // per-channel request fields split out of the flat request buses
   logic [WIDTH-1:0] w_op1Arr [NCH];
   logic [WIDTH-1:0] w_op2Arr [NCH];
   logic [1:0]       w_opArr  [NCH];

   for (genvar g = 0; g < NCH; g++) begin : g_slice
      assign w_op1Arr[g] = req_op1[g*WIDTH +: WIDTH];
      assign w_op2Arr[g] = req_op2[g*WIDTH +: WIDTH];
      assign w_opArr[g]  = req_op[2*g +: 2];
   end

   // arbiter state and issue-side wires
   logic [CW-1:0]    r_ptr;
   logic [CW-1:0]    w_selCh;
   logic             w_any;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [1:0]       w_opSel;
   logic             w_sgn;
   logic             w_x2;
   logic [PW-1:0]    w_aExt;
   logic [PW-1:0]    w_bExt;
   logic [PW-1:0]    w_prodRaw;
   logic [PW-1:0]    w_prod;

   // pipeline stages
   logic [NST-1:0]   r_vld;
   logic [NST-1:0]   r_sgn;
   logic [CW-1:0]    r_ch   [NST];
   op_e              r_op   [NST];
   logic [PW-1:0]    r_prod [NST];

   // retirement state
   logic [ACCW-1:0]  r_acc  [NCH];
   logic             r_outVld;
   logic [2:0]       r_outCh;
   logic [WIDTH-1:0] r_outLo;
   logic [WIDTH-1:0] r_outHi;

   logic [CW-1:0]    w_rCh;
   logic [ACCW-1:0]  w_accOld;
   logic [ACCW-1:0]  w_ext;
   logic [ACCW-1:0]  w_sum;
   logic [ACCW-1:0]  w_macRes;
   logic [ACCW-1:0]  w_accNew;
   logic [PW-1:0]    w_out;
`ifdef SPARC_MAC_SAT_EN
   localparam logic [ACCW-1:0] P_MAX = {1'b0, {(ACCW-1){1'b1}}};
   localparam logic [ACCW-1:0] P_MIN = {1'b1, {(ACCW-1){1'b0}}};
   logic             w_ovf;
   logic [NCH-1:0]   r_ovf;
`endif

   // round-robin search: first requester at or after the pointer wins
   always_comb begin
      int            k;
      logic [CW-1:0] kc;
      logic          hit;
      k       = 0;
      kc      = '0;
      hit     = 1'b0;
      w_any   = 1'b0;
      w_selCh = '0;
      for (int i = 0; i < NCH; i++) begin
         k = int'(r_ptr) + i;
         if (k >= NCH) k = k - NCH;
         kc  = CW'(k);
         hit = 1'b0;
         for (int j = 0; j < NCH; j++) begin
            if (kc == CW'(j)) hit = req_vld[j];
         end
         if (!w_any && hit) begin
            w_any   = 1'b1;
            w_selCh = kc;
         end
      end
      if (hold) w_any = 1'b0;
   end

   // one-hot grant decode
   always_comb begin
      gnt = '0;
      for (int c = 0; c < NCH; c++) begin
         gnt[c] = w_any && (w_selCh == CW'(c));
      end
   end

   // operand mux and product; sign/zero extension to 2W keeps one multiplier
   always_comb begin
      w_a     = '0;
      w_b     = '0;
      w_opSel = 2'b00;
      w_sgn   = 1'b0;
      w_x2    = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (w_selCh == CW'(c)) begin
            w_a     = w_op1Arr[c];
            w_b     = w_op2Arr[c];
            w_opSel = w_opArr[c];
            w_sgn   = req_sgn[c];
            w_x2    = req_x2[c];
         end
      end
      w_aExt    = w_sgn ? {{WIDTH{w_a[WIDTH-1]}}, w_a} : {{WIDTH{1'b0}}, w_a};
      w_bExt    = w_sgn ? {{WIDTH{w_b[WIDTH-1]}}, w_b} : {{WIDTH{1'b0}}, w_b};
      w_prodRaw = w_aExt * w_bExt;
      w_prod    = w_x2 ? {w_prodRaw[PW-2:0], 1'b0} : w_prodRaw;
   end

   // pointer moves past the granted channel; frozen while hold is high
   always_ff @(posedge rclk or negedge rst_l) begin
      if (!rst_l) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= (w_selCh == CW'(NCH-1)) ? '0 : w_selCh + 1'b1;
      end
   end

   // pipeline shift register carrying valid, channel, opcode and product
   always_ff @(posedge rclk or negedge rst_l) begin
      if (!rst_l) begin
         r_vld <= '0;
         r_sgn <= '0;
         for (int i = 0; i < NST; i++) begin
            r_ch[i]   <= '0;
            r_op[i]   <= OP_MUL;
            r_prod[i] <= '0;
         end
      end else if (!hold) begin
         r_vld[0]  <= w_any;
         r_sgn[0]  <= w_sgn;
         r_ch[0]   <= w_selCh;
         r_op[0]   <= op_e'(w_opSel);
         r_prod[0] <= w_prod;
         for (int i = 1; i < NST; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_sgn[i]  <= r_sgn[i-1];
            r_ch[i]   <= r_ch[i-1];
            r_op[i]   <= r_op[i-1];
            r_prod[i] <= r_prod[i-1];
         end
      end
   end

   // retirement datapath: accumulator read, extend, add, opcode result
   always_comb begin
      w_rCh    = r_ch[LS];
      w_accOld = '0;
      for (int c = 0; c < NCH; c++) begin
         if (w_rCh == CW'(c)) w_accOld = r_acc[c];
      end
      w_ext = ACCW'(r_prod[LS]) | ((r_sgn[LS] && r_prod[LS][PW-1]) ? P_HIMASK : '0);
      w_sum = w_accOld + w_ext;
`ifdef SPARC_MAC_SAT_EN
      w_ovf    = (w_accOld[ACCW-1] == w_ext[ACCW-1]) && (w_sum[ACCW-1] != w_accOld[ACCW-1]);
      w_macRes = w_ovf ? (w_accOld[ACCW-1] ? P_MIN : P_MAX) : w_sum;
`else
      w_macRes = w_sum;
`endif
      w_accNew = w_accOld;
      w_out    = '0;
      case (r_op[LS])
         OP_MUL: begin
            w_out = r_prod[LS];
         end
         OP_MAC: begin
            w_accNew = w_macRes;
            w_out    = w_macRes[PW-1:0];
         end
         OP_SHR: begin
            w_out    = w_accOld[PW-1:0];
            w_accNew = w_accOld >> WIDTH;
         end
         OP_CLR: begin
            w_out    = w_accOld[PW-1:0];
            w_accNew = '0;
         end
         default: begin
            w_out = '0;
         end
      endcase
   end

   // registered result and accumulator write-back on the same edge
   always_ff @(posedge rclk or negedge rst_l) begin
      if (!rst_l) begin
         r_outVld <= 1'b0;
         r_outCh  <= '0;
         r_outLo  <= '0;
         r_outHi  <= '0;
         for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
      end else if (hold) begin
         r_outVld <= 1'b0;
      end else begin
         r_outVld <= r_vld[LS];
         if (r_vld[LS]) begin
            r_outCh <= 3'(w_rCh);
            r_outLo <= w_out[WIDTH-1:0];
            r_outHi <= w_out[PW-1:WIDTH];
            for (int c = 0; c < NCH; c++) begin
               if (w_rCh == CW'(c)) r_acc[c] <= w_accNew;
            end
         end
      end
   end

`ifdef SPARC_MAC_SAT_EN
   // sticky overflow: set by an overflowing MAC, cleared only by CLR
   always_ff @(posedge rclk or negedge rst_l) begin
      if (!rst_l) begin
         r_ovf <= '0;
      end else if (!hold && r_vld[LS]) begin
         for (int c = 0; c < NCH; c++) begin
            if (w_rCh == CW'(c)) begin
               if (r_op[LS] == OP_CLR) r_ovf[c] <= 1'b0;
               else if (r_op[LS] == OP_MAC && w_ovf) r_ovf[c] <= 1'b1;
            end
         end
      end
   end

   assign acc_ovf = r_ovf;
`else
   assign acc_ovf = '0;
`endif

   assign out_vld = r_outVld;
   assign out_ch  = r_outCh;
   assign out_lo  = r_outLo;
   assign out_hi  = r_outHi;

endmodule

// File: tb/tb_sparc_mac_dp.sv
// Testbench for sparc_mac_dp: a default 64-bit two-channel instance and an
// 8-bit single-channel instance (GUARD = 0) for the wrap/saturation cases.
`timescale 1ns/1ps
module tb_sparc_mac_dp;

   localparam int W  = 64;
   localparam int N  = 2;
   localparam int L  = 4;
   localparam int L8 = 2;
   localparam logic [1:0] MUL = 2'b00;
   localparam logic [1:0] MAC = 2'b01;
   localparam logic [1:0] SHR = 2'b10;
   localparam logic [1:0] CLR = 2'b11;

   logic             rclk  = 1'b0;
   logic             rst_l = 1'b0;
   logic             hold  = 1'b0;
   logic [N-1:0]     req_vld = '0;
   logic [2*N-1:0]   req_op  = '0;
   logic [W*N-1:0]   req_op1 = '0;
   logic [W*N-1:0]   req_op2 = '0;
   logic [N-1:0]     req_sgn = '0;
   logic [N-1:0]     req_x2  = '0;
   logic [N-1:0]     gnt;
   logic             out_vld;
   logic [2:0]       out_ch;
   logic [W-1:0]     out_lo;
   logic [W-1:0]     out_hi;
   logic [N-1:0]     acc_ovf;

   logic             hold8 = 1'b0;
   logic [0:0]       s8Vld = '0;
   logic [1:0]       s8Op  = '0;
   logic [7:0]       s8Op1 = '0;
   logic [7:0]       s8Op2 = '0;
   logic [0:0]       s8Sgn = '0;
   logic [0:0]       s8X2  = '0;
   logic [0:0]       s8Gnt;
   logic             s8OutVld;
   logic [2:0]       s8OutCh;
   logic [7:0]       s8OutLo;
   logic [7:0]       s8OutHi;
   logic [0:0]       s8Ovf;

   typedef struct {
      logic [2:0]   ch;
      logic [63:0]  lo;
      logic [63:0]  hi;
      int           cyc;
   } exp_t;

   typedef struct {
      logic [15:0]  val;
      int           cyc;
   } exp8_t;

   exp_t  sbQ[$];
   exp8_t sb8Q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;

   sparc_mac_dp #(.WIDTH(W), .NCH(N), .LAT(L), .GUARD(8)) u_dut (
      .rclk    (rclk),
      .rst_l   (rst_l),
      .hold    (hold),
      .req_vld (req_vld),
      .req_op  (req_op),
      .req_op1 (req_op1),
      .req_op2 (req_op2),
      .req_sgn (req_sgn),
      .req_x2  (req_x2),
      .gnt     (gnt),
      .out_vld (out_vld),
      .out_ch  (out_ch),
      .out_lo  (out_lo),
      .out_hi  (out_hi),
      .acc_ovf (acc_ovf)
   );

   sparc_mac_dp #(.WIDTH(8), .NCH(1), .LAT(L8), .GUARD(0)) u_dut8 (
      .rclk    (rclk),
      .rst_l   (rst_l),
      .hold    (hold8),
      .req_vld (s8Vld),
      .req_op  (s8Op),
      .req_op1 (s8Op1),
      .req_op2 (s8Op2),
      .req_sgn (s8Sgn),
      .req_x2  (s8X2),
      .gnt     (s8Gnt),
      .out_vld (s8OutVld),
      .out_ch  (s8OutCh),
      .out_lo  (s8OutLo),
      .out_hi  (s8OutHi),
      .acc_ovf (s8Ovf)
   );

   always #5 rclk = ~rclk;

   always @(posedge rclk) cyc <= cyc + 1;

   // retire side of the wide instance: pop the oldest expectation per result
   always @(negedge rclk) begin
      exp_t e;
      if (out_vld === 1'b1) begin
         checks++;
         if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected: out_vld=1 ch=%0d lo=%h hi=%h, required out_vld=0", out_ch, out_lo, out_hi);
         end else begin
            e = sbQ.pop_front();
            if (out_ch !== e.ch || out_lo !== e.lo || out_hi !== e.hi) begin
               errors++;
               $display("[TB] FAIL sb_data: got ch=%0d hi=%h lo=%h, required ch=%0d hi=%h lo=%h", out_ch, out_hi, out_lo, e.ch, e.hi, e.lo);
            end else if (e.cyc >= 0 && cyc != e.cyc) begin
               errors++;
               $display("[TB] FAIL sb_latency: result in cycle %0d, required cycle %0d", cyc, e.cyc);
            end
         end
      end
   end

   // retire side of the 8-bit instance
   always @(negedge rclk) begin
      exp8_t e;
      if (s8OutVld === 1'b1) begin
         checks++;
         if (sb8Q.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb8_unexpected: out_vld=1 val=%h, required out_vld=0", {s8OutHi, s8OutLo});
         end else begin
            e = sb8Q.pop_front();
            if ({s8OutHi, s8OutLo} !== e.val || s8OutCh !== 3'd0) begin
               errors++;
               $display("[TB] FAIL sb8_data: got ch=%0d val=%h, required ch=0 val=%h", s8OutCh, {s8OutHi, s8OutLo}, e.val);
            end else if (cyc != e.cyc) begin
               errors++;
               $display("[TB] FAIL sb8_latency: result in cycle %0d, required cycle %0d", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic setReq(input int ch, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic sgn, input logic x2);
      if (ch == 0) begin
         req_op[1:0]    = op;
         req_op1[63:0]  = a;
         req_op2[63:0]  = b;
         req_sgn[0]     = sgn;
         req_x2[0]      = x2;
         req_vld[0]     = 1'b1;
      end else begin
         req_op[3:2]     = op;
         req_op1[127:64] = a;
         req_op2[127:64] = b;
         req_sgn[1]      = sgn;
         req_x2[1]       = x2;
         req_vld[1]      = 1'b1;
      end
   endtask

   // drive one request until granted, queue its expected result
   task automatic issue(input int ch, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic sgn, input logic x2,
                        input logic [63:0] expLo, input logic [63:0] expHi, input bit chkLat);
      bit         got = 0;
      logic [1:0] m;
      exp_t       e;
      m = 2'b01 << ch;
      setReq(ch, op, a, b, sgn, x2);
      for (int n = 0; n < 20 && !got; n++) begin
         #1;
         if ((gnt & m) === m) begin
            got   = 1;
            e.ch  = 3'(ch);
            e.lo  = expLo;
            e.hi  = expHi;
            e.cyc = chkLat ? cyc + L : -1;
            sbQ.push_back(e);
         end
         @(negedge rclk);
      end
      if (ch == 0) req_vld[0] = 1'b0;
      else req_vld[1] = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL issue_timeout: ch%0d never granted, required a grant within 20 cycles", ch);
      end
   endtask

   task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic sgn, input logic [15:0] expVal);
      bit    got = 0;
      exp8_t e;
      s8Op  = op;
      s8Op1 = a;
      s8Op2 = b;
      s8Sgn = sgn;
      s8X2  = 1'b0;
      s8Vld = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
         #1;
         if (s8Gnt === 1'b1) begin
            got   = 1;
            e.val = expVal;
            e.cyc = cyc + L8;
            sb8Q.push_back(e);
         end
         @(negedge rclk);
      end
      s8Vld = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL issue8_timeout: never granted, required a grant within 20 cycles");
      end
   endtask

   task automatic waitDrain();
      for (int n = 0; n < 40 && (sbQ.size() + sb8Q.size()) != 0; n++) begin
         @(negedge rclk);
         #2;
      end
      checks++;
      if ((sbQ.size() + sb8Q.size()) != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sbQ.size() + sb8Q.size());
         sbQ.delete();
         sb8Q.delete();
      end
      @(negedge rclk);
   endtask

   task automatic doReset();
      rst_l   = 1'b0;
      req_vld = '0;
      s8Vld   = '0;
      hold    = 1'b0;
      sbQ.delete();
      sb8Q.delete();
      repeat (2) @(negedge rclk);
      rst_l = 1'b1;
      @(negedge rclk);
   endtask

   // reset values of all outputs, then idle with no requests
   task automatic test_reset();
      rst_l   = 1'b0;
      req_vld = '0;
      @(negedge rclk);
      #1;
      checks++;
      if (out_vld !== 1'b0 || out_ch !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_vld_ch: out_vld=%b out_ch=%0d, required 0 0", out_vld, out_ch);
      end
      checks++;
      if (out_lo !== '0 || out_hi !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data: hi=%h lo=%h, required 0 0", out_hi, out_lo);
      end
      checks++;
      if (acc_ovf !== '0 || s8Ovf !== '0) begin
         errors++;
         $display("[TB] FAIL reset_ovf: acc_ovf=%b ovf8=%b, required 0 0", acc_ovf, s8Ovf);
      end
      @(negedge rclk);
      rst_l = 1'b1;
      repeat (2) begin
         @(negedge rclk);
         #1;
         checks++;
         if (gnt !== 2'b00 || out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle: gnt=%b out_vld=%b, required 00 0", gnt, out_vld);
         end
      end
   endtask

   task automatic test_mul();
      issue(0, MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b1);
      waitDrain();
   endtask

   task automatic test_signed_x2();
      issue(1, MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFE2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      waitDrain();
   endtask

   // accumulate chain on ch0, including a shift of a value above 2^64
   task automatic test_accumulate();
      issue(0, CLR, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0,  64'd0, 1'b1);
      issue(0, MAC, 64'd7, 64'd6, 1'b0, 1'b0, 64'd42, 64'd0, 1'b1);
      issue(0, MAC, 64'd2, 64'd3, 1'b0, 1'b0, 64'd48, 64'd0, 1'b1);
      waitDrain();
      issue(0, SHR, 64'd0, 64'd0, 1'b0, 1'b0, 64'd48, 64'd0, 1'b1);
      issue(0, MAC, 64'd1, 64'd1, 1'b0, 1'b0, 64'd1,  64'd0, 1'b1);
      issue(0, MAC, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
            64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      issue(0, SHR, 64'd0, 64'd0, 1'b0, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      issue(0, CLR, 64'd0, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1);
      waitDrain();
   endtask

   // both channels request for 6 cycles with one hold cycle in the middle
   task automatic test_arbitration();
      logic [1:0]  expG [6];
      int          opn  [2];
      logic [63:0] a;
      logic [63:0] b;
      logic [1:0]  m;
      exp_t        e;
      expG = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
      opn  = '{0, 0};
      doReset();
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 2; c++) begin
            a = 64'(16 * c + opn[c] + 1);
            b = 64'(opn[c] + 3);
            setReq(c, MUL, a, b, 1'b0, 1'b0);
         end
         hold = (k == 3);
         #1;
         checks++;
         if (gnt !== expG[k]) begin
            errors++;
            $display("[TB] FAIL arb_gnt%0d: gnt=%b, required %b", k, gnt, expG[k]);
         end
         for (int c = 0; c < 2; c++) begin
            m = 2'b01 << c;
            if ((gnt & m) === m) begin
               a     = 64'(16 * c + opn[c] + 1);
               b     = 64'(opn[c] + 3);
               e.ch  = 3'(c);
               e.lo  = a * b;
               e.hi  = 64'd0;
               e.cyc = -1;
               sbQ.push_back(e);
               opn[c]++;
            end
         end
         @(negedge rclk);
      end
      req_vld = '0;
      hold    = 1'b0;
      waitDrain();
   endtask

   // asynchronous reset while three MACs are in flight
   task automatic test_reset_midflight();
      issue(0, MAC, 64'd1, 64'd1, 1'b0, 1'b0, 64'd1, 64'd0, 1'b1);
      waitDrain();
      issue(0, MAC, 64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 64'd0, 1'b0);
      issue(0, MAC, 64'd1, 64'd1, 1'b0, 1'b0, 64'd3, 64'd0, 1'b0);
      issue(0, MAC, 64'd1, 64'd1, 1'b0, 1'b0, 64'd4, 64'd0, 1'b0);
      rst_l = 1'b0;
      sbQ.delete();
      for (int n = 0; n < 6; n++) begin
         @(negedge rclk);
         if (n == 1) rst_l = 1'b1;
         checks++;
         if (out_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midflight_vld%0d: out_vld=%b, required 0", n, out_vld);
         end
      end
      issue(0, MAC, 64'd1, 64'd1, 1'b0, 1'b0, 64'd1, 64'd0, 1'b1);
      waitDrain();
   endtask

   // repeated signed 127*127 MACs on a 16-bit accumulator
   task automatic test_saturation();
`ifdef SPARC_MAC_SAT_EN
      logic [15:0] v3  = 16'h7FFF;
      logic [15:0] v4  = 16'h7FFF;
      logic        ovf = 1'b1;
`else
      logic [15:0] v3  = 16'hBD03;
      logic [15:0] v4  = 16'hFC04;
      logic        ovf = 1'b0;
`endif
      issue8(CLR, 8'd0, 8'd0, 1'b0, 16'h0000);
      issue8(MAC, 8'd127, 8'd127, 1'b1, 16'h3F01);
      issue8(MAC, 8'd127, 8'd127, 1'b1, 16'h7E02);
      issue8(MAC, 8'd127, 8'd127, 1'b1, v3);
      issue8(MAC, 8'd127, 8'd127, 1'b1, v4);
      waitDrain();
      checks++;
      if (s8Ovf !== ovf) begin
         errors++;
         $display("[TB] FAIL sat_ovf_set: acc_ovf=%b, required %b", s8Ovf, ovf);
      end
      issue8(CLR, 8'd0, 8'd0, 1'b0, v4);
      waitDrain();
      checks++;
      if (s8Ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sat_ovf_clr: acc_ovf=%b, required 0", s8Ovf);
      end
      issue8(MAC, 8'hFF, 8'd3, 1'b1, 16'hFFFD);
      issue8(MAC, 8'd1, 8'd1, 1'b0, 16'hFFFE);
      waitDrain();
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_mul();
      test_signed_x2();
      test_accumulate();
      test_arbitration();
      test_reset_midflight();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sparc_mac_dp.md
# sparc_mac_dp

Parametrised multiply-accumulate datapath for the SPARC core, successor to the single-accumulator EXU/SPU multiplier datapath. It serves NCH requesters through a round-robin arbiter and a fully pipelined multiplier of depth LAT. Each channel has a private wide accumulator. The block sits between the execution/crypto units and their writeback paths.

## Interface
- WIDTH, 64: operand width in bits; valid range 8..64.
- NCH, 2: number of requesting channels; valid range 1..8.
- LAT, 4: grant-to-result latency in cycles; valid range 2..8.
- GUARD, 8: accumulator guard bits. ACCW = 2*WIDTH+GUARD.
- rclk  in  1  clock; all state changes on the rising edge.
- rst_l  in  1  reset, asynchronous, active-low.
- hold  in  1  pipeline freeze; mirrors the mul_step function.
- req_vld  in  NCH  per-channel request.
- req_op  in  2*NCH  per-channel opcode: 00 MUL, 01 MAC, 10 SHR, 11 CLR.
- req_op1, req_op2  in  WIDTH*NCH each  per-channel operands; channel c occupies bits [c*WIDTH +: WIDTH].
- req_sgn  in  NCH  1 = signed two's-complement operands, 0 = unsigned.
- req_x2  in  NCH  1 = product doubled (op1*op2*2).
- gnt  out  NCH  one-hot grant, combinational.
- out_vld  out  1  result valid.
- out_ch  out  3  channel of the result.
- out_lo, out_hi  out  WIDTH each  result low and high words.
- acc_ovf  out  NCH  sticky per-channel overflow flag.

## Operation
- Arbiter:
  - A round-robin pointer starts at channel 0 after reset.
  - Priority goes to the first requesting channel at or after (last granted + 1) mod NCH.
  - gnt = 0 whenever hold = 1.
  - Issue rate is at most one grant per cycle.
  - The requester holds req_* stable until it sees gnt. The operands are sampled in the grant cycle.
- Pipeline:
  - LAT stages carry valid, channel, opcode and product. There is no backpressure.
  - Product = op1*op2 (<<1 if x2), 2*WIDTH bits wide, signed or unsigned per req_sgn.
  - The product is sign- or zero-extended to ACCW for accumulation.
- Retirement at the last stage, with acc[c] being the accumulator of out_ch:
  - MUL: out = product[2W-1:0]; acc unchanged.
  - MAC: acc <= acc + product; out = new acc[2W-1:0].
  - SHR: out = old acc[2W-1:0]; acc <= acc >> WIDTH, logical (zero-fill).
  - CLR: out = old acc[2W-1:0]; acc <= 0; acc_ovf[c] <= 0.
  - out_lo = out[W-1:0], out_hi = out[2W-1:W].
- Ordering:
  - Retirement is strictly in order.
  - Back-to-back MACs to one channel each see the previous update. No hazard stall exists.
- Overflow: a MAC whose signed ACCW-bit sum overflows sets acc_ovf[c]. Only CLR or reset clears it.

## Timing
- Reset (asynchronous, rst_l = 0) clears:
  - all stage valids;
  - out_vld, out_ch, out_lo and out_hi (all to 0);
  - every accumulator and acc_ovf (to 0);
  - the round-robin pointer (to 0).
- Reset mid-operation discards all in-flight operations.
- Latency: a grant in cycle T produces out_vld = 1 in cycle T+LAT. The output is registered. The accumulator updates on the same edge.
- hold = 1:
  - freezes all stages, the accumulators and the pointer;
  - forces out_vld = 0.
  - On release, the op sitting at the last stage retires in the first cycle after release.
- Throughput: with all channels requesting continuously, channels are served 0,1,...,NCH-1,0,...
- A channel may have up to LAT ops in flight.
- With NCH = 1, gnt = req_vld & ~hold.

## Configuration
- SPARC_MAC_SAT_EN defined:
  - A MAC whose sum overflows saturates the accumulator at the signed ACCW maximum or minimum instead of wrapping.
  - acc_ovf sets as described in Operation.
- SPARC_MAC_SAT_EN undefined:
  - The accumulator wraps modulo 2^ACCW.
  - acc_ovf is tied to 0 and no overflow logic is built.

## Test plan
- Reset/MUL (WIDTH=64, LAT=4): ch0 MUL unsigned 0xFFFFFFFF_FFFFFFFF * 2 -> 4 cycles later out_vld = 1, out_ch = 0, out_hi = 0x1, out_lo = 0xFFFFFFFF_FFFFFFFE.
- Signed/x2: ch1 MUL signed, x2 = 1, op1 = -3, op2 = 5 -> {out_hi, out_lo} = -30 (out_hi = all ones, out_lo = 0xFFFF_FFFF_FFFF_FFE2).
- Accumulate chain: ch0 issues CLR, then MAC 7*6, then MAC 2*3 back to back -> results 0, 42, 48 on consecutive out_vld cycles. Then SHR -> out_lo = 48, and a following MAC 1*1 returns 1.
- Arbitration: ch0 and ch1 request continuously for 6 cycles with one hold = 1 cycle in the middle -> gnt alternates 01, 10, 01; gnt = 00 during hold; alternation continues after release. Results retire in grant order with the hold bubble.
- Async reset mid-flight: assert rst_l = 0 two cycles after 3 grants -> out_vld never rises, and a following MAC 1*1 returns 1 (accumulator was cleared).
- Saturation (WIDTH=8, GUARD=0, macro defined): ch0 repeats MAC signed 127*127 -> acc sticks at 0x7FFF and acc_ovf[0] = 1. A following CLR clears both. Without the macro the acc wraps and acc_ovf = 0.
